// File: rtl/prg_port_ctrl.sv
// Byte-command sequencer driving the monitor (prg_*) port of the program/data RAM from a host byte link.
// Latency: write data byte -> prg_we +1 clk -> ack tx_valid +2 clk; reads wait RD_LATENCY+1 clks in RD_WAIT.
// Backpressure: rx_ready only while collecting bytes; tx_valid/tx_data held until tx_ready, stalling the command.
module prg_port_ctrl #(
    parameter int         RD_LATENCY = 1,
    parameter logic [7:0] ACK_BYTE   = 8'h2E,
    parameter logic [7:0] ERR_BYTE   = 8'h3F
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       prg_we,
    output logic [7:0] prg_MA,
    output logic [7:0] prg_WD,
    input  logic [7:0] prg_RD,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, GET_ADDR, GET_ARG, WRITE, RD_WAIT, SEND} state_t;
    typedef enum logic [1:0] {CMD_W, CMD_R, CMD_D, CMD_E} cmd_t;

    localparam logic [1:0] LAT = 2'(RD_LATENCY);

    state_t     state, state_nxt;
    cmd_t       cmd;
    logic [8:0] remaining;
    logic [1:0] wait_cnt;
    logic       rx_fire, tx_fire, is_cmd;

    assign rx_fire = rx_valid & rx_ready;
    assign tx_fire = tx_valid & tx_ready;
    assign is_cmd  = (rx_data == 8'h57) || (rx_data == 8'h52) || (rx_data == 8'h44);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (rx_fire) state_nxt = is_cmd ? GET_ADDR : SEND;
            GET_ADDR: if (rx_fire) state_nxt = (cmd == CMD_R) ? RD_WAIT : GET_ARG;
            GET_ARG:  if (rx_fire) state_nxt = (cmd == CMD_W) ? WRITE : RD_WAIT;
            WRITE:    state_nxt = SEND;
            // RAM samples prg_MA in the first RD_WAIT cycle; data is valid LAT cycles later
            RD_WAIT:  if (wait_cnt == LAT) state_nxt = SEND;
            SEND: begin
                if (tx_fire) state_nxt = (cmd == CMD_D && remaining != 9'd1) ? RD_WAIT : IDLE;
            end
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rx_ready = 1'b0;
        tx_valid = 1'b0;
        prg_we   = 1'b0;
        busy     = 1'b1;
        case (state)
            IDLE: begin
                rx_ready = ~reset;
                busy     = 1'b0;
            end
            GET_ADDR, GET_ARG: rx_ready = ~reset;
            WRITE:             prg_we   = 1'b1;
            SEND:              tx_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cmd       <= CMD_E;
            tx_data   <= 8'h00;
            prg_MA    <= 8'h00;
            prg_WD    <= 8'h00;
            remaining <= 9'd0;
            wait_cnt  <= 2'd0;
        end else begin
            wait_cnt <= (state == RD_WAIT) ? wait_cnt + 2'd1 : 2'd0;
            case (state)
                IDLE: if (rx_fire) begin
                    case (rx_data)
                        8'h57:   cmd <= CMD_W;
                        8'h52:   cmd <= CMD_R;
                        8'h44:   cmd <= CMD_D;
                        default: begin
                            cmd     <= CMD_E;
                            tx_data <= ERR_BYTE;
                        end
                    endcase
                end
                GET_ADDR: if (rx_fire) prg_MA <= rx_data;
                GET_ARG: if (rx_fire) begin
                    if (cmd == CMD_W) prg_WD <= rx_data;
                    else remaining <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                end
                WRITE: tx_data <= ACK_BYTE;
                RD_WAIT: if (wait_cnt == LAT) tx_data <= prg_RD;
                SEND: if (tx_fire && cmd == CMD_D) begin
                    remaining <= remaining - 9'd1;
                    if (remaining != 9'd1) prg_MA <= prg_MA + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
